// File: rtl/la_trigger_pkg.sv
// Shared types for the logic-analyzer trigger unit.
// Holds the sequencer state encoding and the capturing-state helper.
package la_trigger_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT0 = 3'd1,
        WAIT1 = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } trigger_state_t;

    // Samples are forwarded to the analyzer only while a run is in progress.
    function automatic logic is_capturing(input trigger_state_t s);
        return (s == WAIT0) || (s == WAIT1) || (s == POST);
    endfunction

endpackage

// File: rtl/la_pattern_match.sv
// Masked equality compare of a sample against a pattern; purely combinational, no flow control.
// A mask bit of 1 includes that bit in the compare, so an all-zero mask matches anything.
module la_pattern_match #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] mask,
    output logic             match
);

    assign match = (((data ^ value) & mask) == '0);

endmodule

// File: rtl/la_trigger_unit.sv
// Two-stage masked trigger sequencer with occurrence count and post-trigger delay; all outputs 1 cycle.
// No backpressure: every valid sample is consumed the cycle it is presented.
import la_trigger_pkg::*;

module la_trigger_unit #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       sample_data,
    input  logic                   sample_valid,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [WIDTH-1:0]       stage0_value,
    input  logic [WIDTH-1:0]       stage0_mask,
    input  logic [WIDTH-1:0]       stage1_value,
    input  logic [WIDTH-1:0]       stage1_mask,
    input  logic                   stage1_enable,
    input  logic [COUNT_WIDTH-1:0] match_count,
    input  logic [COUNT_WIDTH-1:0] post_trigger_samples,
    output logic [WIDTH-1:0]       capture_data,
    output logic                   capture_enable,
    output logic                   trigger,
    output logic                   armed,
    output logic                   triggered
);

    trigger_state_t state_q, state_d;

    logic [WIDTH-1:0]       stage0_value_q, stage0_mask_q;
    logic [WIDTH-1:0]       stage1_value_q, stage1_mask_q;
    logic                   stage1_enable_q;
    logic [COUNT_WIDTH-1:0] match_count_q;
    logic [COUNT_WIDTH-1:0] post_samples_q;

    logic [COUNT_WIDTH-1:0] occ_cnt_q, occ_cnt_d;
    logic [COUNT_WIDTH-1:0] post_cnt_q, post_cnt_d;
    logic [COUNT_WIDTH-1:0] occ_inc;
    logic [COUNT_WIDTH-1:0] occ_thresh;

    logic match0, match1;
    logic load_cfg;
    logic fire;
    logic trigger_d;
    logic capture_enable_d;

    la_pattern_match #(.WIDTH(WIDTH)) u_match0 (
        .data  (sample_data),
        .value (stage0_value_q),
        .mask  (stage0_mask_q),
        .match (match0)
    );

    la_pattern_match #(.WIDTH(WIDTH)) u_match1 (
        .data  (sample_data),
        .value (stage1_value_q),
        .mask  (stage1_mask_q),
        .match (match1)
    );

    // Saturating increment; a zero occurrence target is treated as one.
    assign occ_inc    = (occ_cnt_q == '1) ? occ_cnt_q : occ_cnt_q + COUNT_WIDTH'(1);
    assign occ_thresh = (match_count_q == '0) ? COUNT_WIDTH'(1) : match_count_q;

    always_comb begin
        state_d    = state_q;
        occ_cnt_d  = occ_cnt_q;
        post_cnt_d = post_cnt_q;
        load_cfg   = 1'b0;
        fire       = 1'b0;
        trigger_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d    = WAIT0;
                    occ_cnt_d  = '0;
                    post_cnt_d = '0;
                    load_cfg   = 1'b1;
                end
            end
            WAIT0: begin
                if (sample_valid && match0) begin
                    if (stage1_enable_q) begin
                        state_d = WAIT1;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            WAIT1: begin
                if (sample_valid && match1) begin
                    occ_cnt_d = occ_inc;
                    if (occ_inc >= occ_thresh) begin
                        fire = 1'b1;
                    end
                end
            end
            POST: begin
                if (sample_valid) begin
                    if (post_cnt_q <= COUNT_WIDTH'(1)) begin
                        post_cnt_d = '0;
                        trigger_d  = 1'b1;
                        state_d    = DONE;
                    end else begin
                        post_cnt_d = post_cnt_q - COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The trigger event either closes the run on this sample or opens the post window.
        if (fire) begin
            if (post_samples_q == '0) begin
                trigger_d = 1'b1;
                state_d   = DONE;
            end else begin
                post_cnt_d = post_samples_q;
                state_d    = POST;
            end
        end

        if (abort) begin
            state_d   = IDLE;
            load_cfg  = 1'b0;
            trigger_d = 1'b0;
        end

        capture_enable_d = sample_valid && is_capturing(state_q) && !abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            stage0_value_q  <= '0;
            stage0_mask_q   <= '0;
            stage1_value_q  <= '0;
            stage1_mask_q   <= '0;
            stage1_enable_q <= 1'b0;
            match_count_q   <= '0;
            post_samples_q  <= '0;
            occ_cnt_q       <= '0;
            post_cnt_q      <= '0;
            capture_data    <= '0;
            capture_enable  <= 1'b0;
            trigger         <= 1'b0;
            armed           <= 1'b0;
            triggered       <= 1'b0;
        end else begin
            state_q        <= state_d;
            occ_cnt_q      <= occ_cnt_d;
            post_cnt_q     <= post_cnt_d;
            capture_data   <= sample_data;
            capture_enable <= capture_enable_d;
            trigger        <= trigger_d;
            armed          <= is_capturing(state_d);
            triggered      <= (state_d == DONE);
            if (load_cfg) begin
                stage0_value_q  <= stage0_value;
                stage0_mask_q   <= stage0_mask;
                stage1_value_q  <= stage1_value;
                stage1_mask_q   <= stage1_mask;
                stage1_enable_q <= stage1_enable;
                match_count_q   <= match_count;
                post_samples_q  <= post_trigger_samples;
            end
        end
    end

endmodule

// File: tb/tb_la_trigger_unit.sv
// Directed bench for la_trigger_unit: per-cycle expectations are queued at drive time
// and compared against the registered outputs one cycle later.
module tb_la_trigger_unit;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  sample_data;
    logic          sample_valid;
    logic          arm;
    logic          abort;
    logic [W-1:0]  stage0_value, stage0_mask, stage1_value, stage1_mask;
    logic          stage1_enable;
    logic [CW-1:0] match_count;
    logic [CW-1:0] post_trigger_samples;
    logic [W-1:0]  capture_data;
    logic          capture_enable;
    logic          trigger;
    logic          armed;
    logic          triggered;

    la_trigger_unit #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .sample_data          (sample_data),
        .sample_valid         (sample_valid),
        .arm                  (arm),
        .abort                (abort),
        .stage0_value         (stage0_value),
        .stage0_mask          (stage0_mask),
        .stage1_value         (stage1_value),
        .stage1_mask          (stage1_mask),
        .stage1_enable        (stage1_enable),
        .match_count          (match_count),
        .post_trigger_samples (post_trigger_samples),
        .capture_data         (capture_data),
        .capture_enable       (capture_enable),
        .trigger              (trigger),
        .armed                (armed),
        .triggered            (triggered)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        cap;
        logic        trig;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cycle   = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   cap_cnt = 0;
    int   snap    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cycle) begin
            mon_e = sb.pop_front();
            chk("capture_enable", {31'd0, capture_enable}, {31'd0, mon_e.cap});
            chk("trigger", {31'd0, trigger}, {31'd0, mon_e.trig});
            if (mon_e.cap) chk("capture_data", capture_data, mon_e.data);
        end
        if (capture_enable) cap_cnt++;
    end

    // One clock of stimulus; ec/et are the capture_enable/trigger expected next cycle.
    task automatic drive(input logic [31:0] d, input logic v, input logic ec, input logic et);
        exp_t e;
        sample_data  = d;
        sample_valid = v;
        e.due  = cycle + 1;
        e.cap  = ec;
        e.trig = et;
        e.data = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        arm          = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic flags(input string tag, input logic ea, input logic et);
        chk({tag, "_armed"}, {31'd0, armed}, {31'd0, ea});
        chk({tag, "_triggered"}, {31'd0, triggered}, {31'd0, et});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        sample_data = '0; sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        stage0_value = '0; stage0_mask = '0; stage1_value = '0; stage1_mask = '0;
        stage1_enable = 1'b0; match_count = '0; post_trigger_samples = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_capture_data", capture_data, 32'h0);
        chk("rst_capture_enable", {31'd0, capture_enable}, 32'h0);
        chk("rst_trigger", {31'd0, trigger}, 32'h0);
        flags("rst", 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset asserted mid-POST
        stage1_enable = 1'b0; stage0_value = 32'h33; stage0_mask = 32'hFF;
        post_trigger_samples = 16'd3;
        arm = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        flags("t1_armed", 1'b1, 1'b0);
        drive(32'h33, 1'b1, 1'b1, 1'b0);
        drive(32'h60, 1'b1, 1'b1, 1'b0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("t1_rst_trigger", {31'd0, trigger}, 32'h0);
        chk("t1_rst_capen", {31'd0, capture_enable}, 32'h0);
        chk("t1_rst_data", capture_data, 32'h0);
        flags("t1_rst", 1'b0, 1'b0);
        drive(32'h61, 1'b1, 1'b0, 1'b0);
        drive(32'h62, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;
        drive(32'h63, 1'b1, 1'b0, 1'b0);
        flags("t1_idle", 1'b0, 1'b0);

        // 2: single stage, no post delay
        stage1_enable = 1'b0; stage0_value = 32'hA5; stage0_mask = 32'hFF;
        post_trigger_samples = 16'd0; match_count = 16'd0;
        arm = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        flags("t2_arm", 1'b1, 1'b0);
        drive(32'h10, 1'b1, 1'b1, 1'b0);
        drive(32'hA5, 1'b1, 1'b1, 1'b1);
        flags("t2_done", 1'b0, 1'b1);
        drive(32'hA5, 1'b1, 1'b0, 1'b0);

        // 3: two stages, three stage1 occurrences
        stage1_enable = 1'b1; stage0_value = 32'h01; stage0_mask = 32'hFF;
        stage1_value = 32'h02; stage1_mask = 32'hFF; match_count = 16'd3;
        arm = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'h02, 1'b1, 1'b1, 1'b0);
        drive(32'h01, 1'b1, 1'b1, 1'b0);
        drive(32'h02, 1'b1, 1'b1, 1'b0);
        drive(32'h02, 1'b1, 1'b1, 1'b0);
        flags("t3_wait1", 1'b1, 1'b0);
        drive(32'h02, 1'b1, 1'b1, 1'b1);
        flags("t3_done", 1'b0, 1'b1);

        // 4: post delay of 4 with alternating valid
        stage1_enable = 1'b0; stage0_value = 32'h33; post_trigger_samples = 16'd4;
        arm = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'h11, 1'b1, 1'b1, 1'b0);
        @(negedge clk); #1;
        snap = cap_cnt;
        drive(32'h33, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(32'h40 + 2*i, 1'b0, 1'b0, 1'b0);
            drive(32'h41 + 2*i, 1'b1, 1'b1, (i == 3));
        end
        flags("t4_done", 1'b0, 1'b1);
        @(negedge clk); #1;
        chk("t4_cap_pulses", cap_cnt - snap, 32'd5);

        // 5: abort on the final POST sample
        post_trigger_samples = 16'd2;
        arm = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'h33, 1'b1, 1'b1, 1'b0);
        drive(32'h50, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        drive(32'h51, 1'b1, 1'b0, 1'b0);
        flags("t5_abort", 1'b0, 1'b0);
        drive(32'h52, 1'b1, 1'b0, 1'b0);

        // 6: arm ignored while running, honoured from DONE
        stage1_enable = 1'b1; stage0_value = 32'h01; stage1_value = 32'h02;
        match_count = 16'd2; post_trigger_samples = 16'd0;
        arm = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'h01, 1'b1, 1'b1, 1'b0);
        stage0_value = 32'h77; stage1_value = 32'h09; stage1_enable = 1'b0;
        arm = 1'b1;
        drive(32'h02, 1'b1, 1'b1, 1'b0);
        flags("t6_ignored", 1'b1, 1'b0);
        drive(32'h02, 1'b1, 1'b1, 1'b1);
        flags("t6_done", 1'b0, 1'b1);
        arm = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        flags("t6_rearm", 1'b1, 1'b0);
        drive(32'h01, 1'b1, 1'b1, 1'b0);
        drive(32'h77, 1'b1, 1'b1, 1'b1);
        flags("t6_done2", 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
